signed_mul_arbiter: RTL
=======================

Name: signed_mul_arbiter

Overview:
- Shares one instance of the team's combinational `signed_multiplier` between NUM_REQ requesters.
- Each requester has a valid/ready request channel.
- Arbitration is round-robin; the operand pair is selected through a mux.
- The product is registered into a single-entry output buffer, tagged with the winning requester id, and drained through a valid/ready response channel.

Parameters:
- width, 16, operand width in bits; passed through to `signed_multiplier`.
- result_width, 2*width, product width.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the id tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  bit i = requester i presents operands.
- req_ready  output  NUM_REQ  bit i = requester i's operands are accepted this cycle.
- req_multiplicand  input  NUM_REQ*width  requester i's multiplicand in bits [i*width +: width], two's complement.
- req_multiplier  input  NUM_REQ*width  requester i's multiplier, same packing.
- out_valid  output  1  output buffer holds a result.
- out_ready  input  1  consumer accepts the result.
- out_result  output  result_width  signed product.
- out_id  output  ID_W  index of the requester that produced out_result.

Behaviour:
- Reset (n_rst low, asynchronous): out_valid=0, out_result=0, out_id=0, rr_ptr=0. req_ready is all zeros while reset is asserted.
- Buffer state machine:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - accept = ~out_valid | out_ready, combinational.
- Arbitration:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit is the grant.
  - Grant is one-hot or zero.
  - req_ready[i] = grant[i] & accept, and is combinational.
  - req_ready never depends on req_ready from the same cycle.
  - A request with req_valid low is never granted.
- Transfer: fires when some req_valid[i] & req_ready[i]. On that clock edge:
  - out_result <= signed product of requester i's operands (full result_width, exact, no truncation).
  - out_id <= i.
  - out_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from the request handshake to out_valid.
- Throughput: 1 result per cycle while out_ready stays high.
- Output drain: out_valid & out_ready with no new transfer → out_valid <= 0. out_result and out_id hold their last values.
- Simultaneous drain and new transfer (FULL, out_ready=1, a request pending): the buffer is overwritten with the new result and out_valid stays 1. No bubble.
- Backpressure (FULL, out_ready=0):
  - req_ready all 0.
  - out_result and out_id stay stable.
  - rr_ptr is unchanged.
  - No request is consumed.
- No requests: rr_ptr holds.
- Requesters that keep req_valid high may change operands only after their handshake. Behaviour when operands change while the request is stalled is undefined.
- Fairness: with all requesters continuously valid and out_ready=1, grants go 0,1,2,...,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 transfers.
- Multiplier boundary: -2^(width-1) * -2^(width-1) = +2^(2*width-2), which must be represented exactly.
- Reset mid-operation: any buffered result is discarded (out_valid=0), and arbitration restarts at requester 0 after n_rst deasserts.

Test Plan:
- After reset, req_valid=4'b0001 with operands (-3, 5), out_ready=1. Required: req_ready=4'b0001 that cycle; next cycle out_valid=1, out_result=32'hFFFF_FFF1, out_id=0.
- Requester 2 presents (-32768, -32768). Required: out_result=32'h4000_0000, out_id=2. Then (32767, -32768): out_result=32'hC000_8000.
- All four requesters continuously valid with distinct operands, out_ready=1 for 8 cycles. Required: out_id sequence 0,1,2,3,0,1,2,3 with a result every cycle and correct products.
- A result is pending and out_ready is held 0 for 3 cycles while req_valid=4'b1111. Required: req_ready=0 throughout, out_result and out_id unchanged, rr_ptr unchanged. When out_ready=1, the next grant goes to the expected index with no lost or duplicated result.
- n_rst asserted asynchronously mid-cycle while out_valid=1. Required: out_valid, out_result and out_id go to 0 immediately. After release with req_valid=4'b1010, the first grant is requester 1.
- Random operands, 10k handshakes, random valid/ready toggling. Required: every product matches a scoreboard signed reference, and no requester waits more than NUM_REQ-1 transfers while valid.

Source files
------------

// File: rtl/signed_mul_arbiter.sv
// Round-robin arbiter sharing one combinational signed multiplier between
// NUM_REQ valid/ready requesters, with a single-entry tagged output buffer.

module signed_multiplier #(
  parameter int unsigned width = 16
) (
  input  logic signed [width-1:0]   multiplicand,
  input  logic signed [width-1:0]   multiplier,
  output logic signed [2*width-1:0] product
);

  assign product = multiplicand * multiplier;

endmodule

module signed_mul_arbiter #(
  parameter int unsigned width        = 16,
  parameter int unsigned result_width = 2*width,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*width-1:0]  req_multiplicand,
  input  logic [NUM_REQ*width-1:0]  req_multiplier,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [result_width-1:0]   out_result,
  output logic [ID_W-1:0]           out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic [result_width-1:0]  result_q, result_d;

  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          grant_id;
  logic                     grant_any;
  logic                     accept;
  logic                     fire;
  logic signed [width-1:0]  sel_a, sel_b;
  logic signed [2*width-1:0] product;

  // Scan from rr_ptr with wraparound; the first valid requester wins.
  always_comb begin : arbiter
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = ID_W'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

  always_comb begin : operand_mux
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_multiplicand[i*width +: width];
        sel_b = req_multiplier[i*width +: width];
      end
    end
  end

  // n_rst gates accept so req_ready stays low for the whole reset window.
  assign accept    = n_rst & ((state_q == EMPTY) | out_ready);
  assign req_ready = grant & {NUM_REQ{accept}};
  assign fire      = grant_any & accept;

  signed_multiplier #(.width(width)) u_mul (
    .multiplicand (sel_a),
    .multiplier   (sel_b),
    .product      (product)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      id_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    result_d = result_q;
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL:  if (!fire && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (fire) begin
      result_d = result_width'(product);
      id_d     = grant_id;
      rr_ptr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  always_comb begin : outputs
    out_valid  = (state_q == FULL);
    out_result = result_q;
    out_id     = id_q;
  end

endmodule
